// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor
//   Safety stage between the traffic light controller and the lamp heads.
//   The controller's four lamp vectors are registered and passed through
//   with one cycle of latency. Illegal lamp codes, conflicting "go"
//   indications and illegal or too-short sequences latch a fault. A latched
//   fault flashes all heads red until the operator clears it, then holds
//   solid all-red for a recovery interval before monitoring resumes.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   light_M1_in  controller lamp, main road dir 1   (100 red, 010 yel, 001 grn)
//   light_M2_in  controller lamp, main road dir 2
//   light_MT_in  controller lamp, main road turn
//   light_S_in   controller lamp, side road
//   fault_clr    operator clear pulse, honoured only in FAULT
//   light_M1     lamp head drive, M1
//   light_M2     lamp head drive, M2
//   light_MT     lamp head drive, MT
//   light_S      lamp head drive, S
//   fault        high in FAULT and RECOVER
//   fault_code   first violation cause (001 invalid, 010 conflict,
//                011 sequence, 100 short yellow), cleared on leaving RECOVER
module signal_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 1,
  parameter int ALL_RED    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1_in,
  input  logic [2:0] light_M2_in,
  input  logic [2:0] light_MT_in,
  input  logic [2:0] light_S_in,
  input  logic       fault_clr,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [1:0] ST_MONITOR = 2'd0;
  localparam logic [1:0] ST_FAULT   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic [2:0] LAMP_RED  = 3'b100;
  localparam logic [2:0] LAMP_YEL  = 3'b010;
  localparam logic [2:0] LAMP_GRN  = 3'b001;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  localparam logic [2:0] CODE_NONE     = 3'b000;
  localparam logic [2:0] CODE_INVALID  = 3'b001;
  localparam logic [2:0] CODE_CONFLICT = 3'b010;
  localparam logic [2:0] CODE_SEQUENCE = 3'b011;
  localparam logic [2:0] CODE_SHORT    = 3'b100;

  localparam int CW = $clog2(MIN_YELLOW + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int RW = (ALL_RED > 1) ? $clog2(ALL_RED) : 1;

  localparam logic [CW-1:0] MIN_Y      = CW'(MIN_YELLOW);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [RW-1:0] REC_LAST   = RW'(ALL_RED - 1);

  // Approach index: 0 = M1, 1 = M2, 2 = MT, 3 = S
  logic [2:0]    lamp_in  [4];
  logic [2:0]    lamp_reg [4];
  logic [2:0]    prev_reg [4];
  logic [CW-1:0] ycnt_reg [4];
  logic [CW-1:0] ycnt_next[4];

  logic [1:0]    state_reg;
  logic          fault_reg;
  logic [2:0]    code_reg;
  logic          phase_reg;   // 1 = red on, 0 = dark
  logic [FW-1:0] flash_cnt_reg;
  logic [RW-1:0] rec_cnt_reg;
  logic          hist_valid_reg;

  logic [3:0] valid_vec;
  logic [3:0] go_vec;
  logic [3:0] seq_bad_vec;
  logic [3:0] short_bad_vec;
  logic       conflict;
  logic [2:0] code_next;

  assign lamp_in[0] = light_M1_in;
  assign lamp_in[1] = light_M2_in;
  assign lamp_in[2] = light_MT_in;
  assign lamp_in[3] = light_S_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_approach
      assign valid_vec[gi] = (lamp_in[gi] == LAMP_RED) ||
                             (lamp_in[gi] == LAMP_YEL) ||
                             (lamp_in[gi] == LAMP_GRN);
      assign go_vec[gi]    = (lamp_in[gi] == LAMP_YEL) ||
                             (lamp_in[gi] == LAMP_GRN);

      // Only red->green, green->yellow, yellow->red and hold are legal.
      assign seq_bad_vec[gi] =
        ((prev_reg[gi] == LAMP_GRN) && (lamp_in[gi] == LAMP_RED)) ||
        ((prev_reg[gi] == LAMP_RED) && (lamp_in[gi] == LAMP_YEL)) ||
        ((prev_reg[gi] == LAMP_YEL) && (lamp_in[gi] == LAMP_GRN));

      // ycnt_reg holds how many yellow cycles were seen so far (saturating),
      // so at the yellow->red edge it is the length of the yellow interval.
      assign short_bad_vec[gi] = (prev_reg[gi] == LAMP_YEL) &&
                                 (lamp_in[gi] == LAMP_RED) &&
                                 (ycnt_reg[gi] < MIN_Y);

      always_comb begin
        ycnt_next[gi] = '0;
        if (lamp_in[gi] == LAMP_YEL) begin
          ycnt_next[gi] = (ycnt_reg[gi] >= MIN_Y) ? ycnt_reg[gi]
                                                  : ycnt_reg[gi] + CW'(1);
        end
      end
    end
  endgenerate

  // M1/M2 and M1/MT may run together; every other pairing with S, plus
  // M2 against MT, must never both be go.
  assign conflict = (go_vec[3] && (go_vec[0] || go_vec[1] || go_vec[2])) ||
                    (go_vec[1] && go_vec[2]);

  // History-based checks are skipped on the seeding cycle.
  always_comb begin
    code_next = CODE_NONE;
    if (!(&valid_vec)) begin
      code_next = CODE_INVALID;
    end else if (conflict) begin
      code_next = CODE_CONFLICT;
    end else if (hist_valid_reg && (|seq_bad_vec)) begin
      code_next = CODE_SEQUENCE;
    end else if (hist_valid_reg && (|short_bad_vec)) begin
      code_next = CODE_SHORT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_MONITOR;
      fault_reg      <= 1'b0;
      code_reg       <= CODE_NONE;
      phase_reg      <= 1'b1;
      flash_cnt_reg  <= '0;
      rec_cnt_reg    <= '0;
      hist_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lamp_reg[i] <= LAMP_RED;
        prev_reg[i] <= LAMP_RED;
        ycnt_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_MONITOR: begin
          if (code_next != CODE_NONE) begin
            // The violating sample is dropped; the first FAULT cycle is red.
            state_reg     <= ST_FAULT;
            fault_reg     <= 1'b1;
            code_reg      <= code_next;
            phase_reg     <= 1'b1;
            flash_cnt_reg <= '0;
            for (int i = 0; i < 4; i++) lamp_reg[i] <= LAMP_RED;
          end else begin
            hist_valid_reg <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              lamp_reg[i] <= lamp_in[i];
              prev_reg[i] <= lamp_in[i];
              ycnt_reg[i] <= ycnt_next[i];
            end
          end
        end

        ST_FAULT: begin
          if (fault_clr) begin
            state_reg   <= ST_RECOVER;
            rec_cnt_reg <= '0;
            for (int i = 0; i < 4; i++) lamp_reg[i] <= LAMP_RED;
          end else if (flash_cnt_reg == FLASH_LAST) begin
            flash_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
            // Drive the lamps for the phase being entered.
            for (int i = 0; i < 4; i++)
              lamp_reg[i] <= phase_reg ? LAMP_DARK : LAMP_RED;
          end else begin
            flash_cnt_reg <= flash_cnt_reg + FW'(1);
          end
        end

        ST_RECOVER: begin
          for (int i = 0; i < 4; i++) lamp_reg[i] <= LAMP_RED;
          if (rec_cnt_reg == REC_LAST) begin
            state_reg      <= ST_MONITOR;
            fault_reg      <= 1'b0;
            code_reg       <= CODE_NONE;
            hist_valid_reg <= 1'b0;
            for (int i = 0; i < 4; i++) ycnt_reg[i] <= '0;
          end else begin
            rec_cnt_reg <= rec_cnt_reg + RW'(1);
          end
        end

        default: begin
          state_reg <= ST_MONITOR;
        end
      endcase
    end
  end

  assign light_M1   = lamp_reg[0];
  assign light_M2   = lamp_reg[1];
  assign light_MT   = lamp_reg[2];
  assign light_S    = lamp_reg[3];
  assign fault      = fault_reg;
  assign fault_code = code_reg;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed, table-driven bench for signal_conflict_monitor.
// Each vector is driven before a rising edge; outputs are sampled 1 time
// unit after that edge and compared against hand-computed values.
module tb_signal_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;
  localparam logic [2:0] X = 3'b110;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light_M1_in, light_M2_in, light_MT_in, light_S_in;
  logic       fault_clr;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       fault;
  logic [2:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] in_l;   // {M1, M2, MT, S}
    logic        clr;
    logic [11:0] exp_l;
    logic        exp_f;
    logic [2:0]  exp_c;
  } vec_t;

  vec_t vecs[$];

  signal_conflict_monitor #(
    .MIN_YELLOW(3),
    .FLASH_HALF(1),
    .ALL_RED(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .light_M1_in(light_M1_in),
    .light_M2_in(light_M2_in),
    .light_MT_in(light_MT_in),
    .light_S_in(light_S_in),
    .fault_clr(fault_clr),
    .light_M1(light_M1),
    .light_M2(light_M2),
    .light_MT(light_MT),
    .light_S(light_S),
    .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] l4(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c, input logic [2:0] d);
    return {a, b, c, d};
  endfunction

  task automatic add(input logic [11:0] in_l, input logic clr,
                     input logic [11:0] exp_l, input logic exp_f,
                     input logic [2:0] exp_c);
    vec_t v;
    v.in_l = in_l; v.clr = clr; v.exp_l = exp_l; v.exp_f = exp_f; v.exp_c = exp_c;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [11:0] in_l, input logic clr);
    {light_M1_in, light_M2_in, light_MT_in, light_S_in} = in_l;
    fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] exp_l,
                       input logic exp_f, input logic [2:0] exp_c);
    logic [11:0] act_l;
    act_l = {light_M1, light_M2, light_MT, light_S};
    n_checks++;
    if (act_l !== exp_l) begin
      n_fail++;
      $display("FAIL %s lamps: got %b required %b", name, act_l, exp_l);
    end
    n_checks++;
    if (fault !== exp_f) begin
      n_fail++;
      $display("FAIL %s fault: got %b required %b", name, fault, exp_f);
    end
    n_checks++;
    if (fault_code !== exp_c) begin
      n_fail++;
      $display("FAIL %s fault_code: got %b required %b", name, fault_code, exp_c);
    end
    $display("%s: lamps=%b fault=%b code=%b", name, act_l, fault, fault_code);
  endtask

  initial begin
    logic [11:0] allr, alld;
    allr = l4(R, R, R, R);
    alld = l4(D, D, D, D);

    // Legal pass-through, seeding cycle first
    for (int i = 0; i < 5; i++)
      add(l4(G, G, R, R), 0, l4(G, G, R, R), 0, 3'b000);
    // S green against M1 green: conflict, then flash every cycle
    add(l4(G, G, R, G), 0, allr, 1, 3'b010);
    add(l4(G, G, R, G), 0, alld, 1, 3'b010);
    add(l4(G, G, R, G), 0, allr, 1, 3'b010);
    add(l4(G, G, R, G), 0, alld, 1, 3'b010);
    // Clear, two all-red recovery cycles, back to MONITOR
    add(l4(G, G, R, R), 1, allr, 1, 3'b010);
    add(l4(G, G, R, R), 0, allr, 1, 3'b010);
    add(l4(G, G, R, R), 0, allr, 0, 3'b000);
    // First sample after recovery: M1 green->red across the fault is not a sequence fault
    add(l4(R, G, R, R), 0, l4(R, G, R, R), 0, 3'b000);
    // Short yellow (2 cycles)
    add(l4(G, G, R, R), 0, l4(G, G, R, R), 0, 3'b000);
    add(l4(Y, G, R, R), 0, l4(Y, G, R, R), 0, 3'b000);
    add(l4(Y, G, R, R), 0, l4(Y, G, R, R), 0, 3'b000);
    add(l4(R, G, R, R), 0, allr, 1, 3'b100);
    add(l4(R, G, R, R), 1, allr, 1, 3'b100);
    add(l4(R, G, R, R), 0, allr, 1, 3'b100);
    add(l4(R, G, R, R), 0, allr, 0, 3'b000);
    // Exactly MIN_YELLOW yellow cycles is legal
    add(l4(G, G, R, R), 0, l4(G, G, R, R), 0, 3'b000);
    add(l4(Y, G, R, R), 0, l4(Y, G, R, R), 0, 3'b000);
    add(l4(Y, G, R, R), 0, l4(Y, G, R, R), 0, 3'b000);
    add(l4(Y, G, R, R), 0, l4(Y, G, R, R), 0, 3'b000);
    add(l4(R, G, R, R), 0, l4(R, G, R, R), 0, 3'b000);
    // M2 skips yellow
    add(l4(R, R, R, R), 0, allr, 1, 3'b011);
    add(l4(R, R, R, R), 1, allr, 1, 3'b011);
    add(l4(R, R, R, R), 0, allr, 1, 3'b011);
    add(l4(R, G, R, R), 0, allr, 0, 3'b000);
    // Skipped yellow together with invalid MT: invalid wins
    add(l4(R, G, R, R), 0, l4(R, G, R, R), 0, 3'b000);
    add(l4(R, R, X, R), 0, allr, 1, 3'b001);
    add(l4(R, R, R, R), 1, allr, 1, 3'b001);
    add(l4(R, R, R, R), 0, allr, 1, 3'b001);
    add(l4(R, R, R, R), 0, allr, 0, 3'b000);
    // fault_clr in MONITOR has no effect
    add(l4(G, G, R, R), 1, l4(G, G, R, R), 0, 3'b000);
    // M2 against MT conflict
    add(l4(G, G, G, R), 0, allr, 1, 3'b010);
    add(l4(G, G, G, R), 0, alld, 1, 3'b010);

    // Reset
    rst = 1'b1;
    drive(allr, 0);
    drive(allr, 0);
    check("reset", allr, 0, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in_l, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_f, vecs[i].exp_c);
    end

    // Reset while flashing in FAULT
    rst = 1'b1;
    drive(l4(G, G, G, R), 0);
    check("rst_mid_fault", allr, 0, 3'b000);
    rst = 1'b0;
    drive(l4(G, G, R, R), 1);
    check("after_rst_clr", l4(G, G, R, R), 0, 3'b000);

    // Reset while in RECOVER
    drive(l4(G, G, R, G), 0);
    check("enter_fault", allr, 1, 3'b010);
    drive(l4(G, G, R, R), 1);
    check("enter_recover", allr, 1, 3'b010);
    rst = 1'b1;
    drive(l4(G, G, R, R), 0);
    check("rst_mid_recover", allr, 0, 3'b000);
    rst = 1'b0;
    drive(l4(G, G, R, R), 0);
    check("after_rst_pass", l4(G, G, R, R), 0, 3'b000);

    // fault_clr in RECOVER is ignored (recovery length unchanged)
    drive(l4(G, G, R, G), 0);
    check("fault_again", allr, 1, 3'b010);
    drive(l4(G, G, R, R), 1);
    check("recover1", allr, 1, 3'b010);
    drive(l4(G, G, R, R), 1);
    check("recover2_clr", allr, 1, 3'b010);
    drive(l4(G, G, R, R), 1);
    check("recover_done", allr, 0, 3'b000);
    drive(l4(G, G, R, R), 0);
    check("resume", l4(G, G, R, R), 0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
